sha256_round_engine: RTL and testbench

SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

---
 rtl/sha256_round_engine.sv | 80 ++++++++
 tb/tb_sha256_round_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression, one round per clock with an in-place 16-word message schedule.
module sha256_round_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first,
    input  logic [255:0] h_in,
    input  logic [511:0] msg_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] state_out,
    output logic [31:0]  f_out,
    output logic [1:0]   Block
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] k_rom [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t      st, st_nx;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] w [16];
    logic [5:0]  cnt;
    logic        first_q;
    logic [31:0] t1, t2, w_nx;

    always_comb begin
        t1    = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_rom[cnt] + w[0];
        t2    = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        // w[0] is W(t); the word produced now is W(t+16) and enters at the tail
        w_nx  = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        st_nx = (st == IDLE && start) ? RUN :
                (st == RUN && cnt == 6'd63) ? DONE :
                (st == DONE) ? IDLE : st;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            cnt     <= '0;
            first_q <= 1'b0;
            Block   <= 2'd0;
        end else begin
            st <= st_nx;
            if (st == IDLE && start) begin
                {a, b, c, d, e, f, g, h} <= h_in;
                for (int i = 0; i < 16; i++) w[i] <= msg_in[511 - 32*i -: 32];
                cnt     <= '0;
                first_q <= first;
                if (first) Block <= 2'd0;
            end else if (st == RUN) begin
                {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_nx;
                cnt   <= cnt + 6'd1;
                if (cnt == 6'd63) Block <= first_q ? 2'd1 : 2'd2;
            end
        end
    end

    assign busy      = st != IDLE;
    assign done      = st == DONE;
    assign state_out = {a, b, c, d, e, f, g, h};
    assign f_out     = f;
endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine: directed known-answer tests for the SHA-256 round engine.
module tb_sha256_round_engine;
    logic         clk = 1'b0;
    logic         rst, start, first;
    logic [255:0] h_in;
    logic [511:0] msg_in;
    logic         busy, done;
    logic [255:0] state_out;
    logic [31:0]  f_out;
    logic [1:0]   Block;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [255:0] iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] msg_abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [255:0] st_abc = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                                       32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
    localparam logic [511:0] msg_2a = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] msg_2b = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] dig_2 = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

    sha256_round_engine dut (
        .clk(clk), .rst(rst), .start(start), .first(first), .h_in(h_in), .msg_in(msg_in),
        .busy(busy), .done(done), .state_out(state_out), .f_out(f_out), .Block(Block)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    // lat = cycle index of done (65 expected), 0 on timeout, -1 if aborted by reset
    task automatic run_block(input logic fst, input logic [255:0] hv, input logic [511:0] mv,
                             input int glitch, input int abort, input logic [1:0] blk_run,
                             output int lat);
        @(negedge clk);
        first = fst; h_in = hv; msg_in = mv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; h_in = ~hv; msg_in = ~mv; first = ~fst;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == glitch) start = 1'b1;
            else if (n == glitch + 1) start = 1'b0;
            if (n == 5) check("blk_run", {254'd0, Block}, {254'd0, blk_run});
            if (n == abort) begin
                rst = 1'b1;
                lat = -1;
                break;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    int           lat, ndone, last, pulses;
    logic [255:0] h1, s1;

    initial begin
        rst = 1'b1; start = 1'b0; first = 1'b0; h_in = '0; msg_in = '0;
        #1;
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_state", state_out, 256'd0);
        check("rst_blk", {254'd0, Block}, 256'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_block(1'b1, iv, msg_abc, -1, -1, 2'd0, lat);
        check("abc_lat", lat, 65);
        check("abc_state", state_out, st_abc);
        check("abc_f", {224'd0, f_out}, {224'd0, 32'hfb121210});
        check("abc_h6", {224'd0, f_out + 32'h9b05688c}, {224'd0, 32'h96177a9c});
        check("abc_blk", {254'd0, Block}, 256'd1);
        @(negedge clk);
        check("abc_pulse", {255'd0, done}, 256'd0);
        check("abc_idle", {255'd0, busy}, 256'd0);
        check("abc_hold", state_out, st_abc);

        run_block(1'b1, iv, msg_abc, 10, -1, 2'd0, lat);
        check("gl_lat", lat, 65);
        check("gl_state", state_out, st_abc);
        ndone = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("gl_single", ndone, 0);
        check("gl_idle", {255'd0, busy}, 256'd0);

        run_block(1'b1, iv, msg_abc, -1, 30, 2'd0, lat);
        check("ab_lat", lat, -1);
        #1;
        check("ab_state", state_out, 256'd0);
        check("ab_f", {224'd0, f_out}, 256'd0);
        check("ab_busy", {255'd0, busy}, 256'd0);
        check("ab_blk", {254'd0, Block}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ab_nodone", ndone, 0);
        run_block(1'b1, iv, msg_abc, -1, -1, 2'd0, lat);
        check("re_lat", lat, 65);
        check("re_state", state_out, st_abc);

        run_block(1'b1, iv, msg_2a, -1, -1, 2'd0, lat);
        check("b1_lat", lat, 65);
        check("b1_blk", {254'd0, Block}, 256'd1);
        h1 = add8(iv, state_out);
        run_block(1'b0, h1, msg_2b, -1, -1, 2'd1, lat);
        check("b2_lat", lat, 65);
        check("b2_blk", {254'd0, Block}, 256'd2);
        s1 = add8(h1, state_out);
        check("b2_digest", s1, dig_2);

        @(negedge clk);
        first = 1'b1; h_in = iv; msg_in = msg_abc; start = 1'b1;
        last = -1; pulses = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (last >= 0 && c == last + 1) check("bb_gap", {255'd0, busy}, 256'd0);
            if (last >= 0 && c == last + 2) check("bb_rerun", {255'd0, busy}, 256'd1);
            if (done) begin
                if (last >= 0) check("bb_period", c - last, 66);
                check("bb_state", state_out, st_abc);
                last = c;
                pulses++;
            end
        end
        start = 1'b0;
        check("bb_pulses", pulses, 3);
        repeat (70) @(negedge clk);
        check("bb_end", {255'd0, busy}, 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
